slot_bus_if: RTL and testbench
==============================

# slot_bus_if

Parametrised Apple II slot bus interface, the successor to the combinational data-bus mux in the disk-controller top level. It synchronises the slot strobes to `fclk` and classifies each bus cycle as device register, slot ROM or expansion ROM. It drives read data only after a programmable settle delay, and it tracks expansion-ROM ownership ($CFFF release). It also adds ROM bank switching and a single-cycle device read/write strobe interface for the IWM and future register blocks.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `_devsel`, `_iosel`, `_iostrobe`, `q3`; legal range 2–3.
- `OE_DELAY`, 2: `fclk` cycles between cycle detection and driving data; 0 is legal.
- `ROM_BANKS`, 4: number of 4 KB ROM banks; a power of 2, 1–16.
- `fclk` in 1: 7/8 MHz clock; sole clock.
- `reset` in 1: synchronous, active-high.
- `addr` in 12: bus A11–A0.
- `rw` in 1: 1 = read.
- `q3` in 1: 2 MHz timing signal.
- `_iosel`, `_iostrobe`, `_devsel` in 1 each: active-low slot strobes (asynchronous).
- `data_in` in 8: bus data from pad.
- `rom_q` in 8: ROM output for `rom_addr`.
- `dev_q` in 8: register read data from the selected device.
- `data_out` out 8: bus drive value.
- `data_oe` out 1: pad output enable.
- `_en245` out 1: level-shifter enable, active-low.
- `rom_addr` out 12+log2(ROM_BANKS): `{bank, addr}`.
- `dev_reg` out 4: latched A3–A0 of the devsel cycle.
- `dev_rd_stb`, `dev_wr_stb` out 1 each: one-cycle pulses.
- `dev_wr_data` out 8: captured write data.
- `exp_active` out 1: this card owns $C800–$CFFF.
- `bank` out log2(ROM_BANKS), minimum 1 bit: current ROM bank.

## Operation
**Reset values:** state IDLE, `data_oe`=0, `_en245`=1, `data_out`=0, `dev_rd_stb`=`dev_wr_stb`=0, `dev_reg`=0, `dev_wr_data`=0, `exp_active`=0, `bank`=0.

**Cycle start**
- A falling edge of a synchronised strobe starts a cycle. Priority is devsel > iosel > iostrobe.
- An iostrobe cycle is taken only if `exp_active`=1. Otherwise it is ignored and `_en245` stays 1.
- `addr` and `rw` are latched at cycle start.

**States:** IDLE → SETTLE (OE_DELAY cycles; skipped if 0) → ACCESS → DONE → IDLE.

**ACCESS entry**
- Devsel read: pulse `dev_rd_stb`. Drive `data_out`=`dev_q` only if A0=0; odd addresses still pulse but do not drive.
- ROM read: drive `rom_q`.
- Devsel write: wait in ACCESS until synced `q3`=1 or `_devsel` released, capture `data_in` into `dev_wr_data`, pulse `dev_wr_stb`, go to DONE.
- ROM write: no action.

**DONE:** wait for the synced strobe to return high, then go to IDLE.

**`_en245`:** 0 from SETTLE through DONE for any taken cycle, read or write. `data_oe`=1 only in ACCESS/DONE of a driving read.

**Expansion ROM ownership**
- Any iosel cycle sets `exp_active`.
- An iostrobe cycle with `addr[10:0]`=11'h7FF clears it on exit from DONE. That cycle still drives ROM data.

**Boundary conditions**
- Strobe released during SETTLE: abort to IDLE with no pulses, no capture and no drive.
- A strobe already low when `reset` deasserts is ignored until it rises and falls again.
- `reset` mid-cycle: all outputs take their reset values on that edge.
- `_iosel` and `_iostrobe` low together is illegal. Iosel wins and no assertion is raised.

## Timing
- Pad strobe fall visible at sync output after SYNC_STAGES edges. The state leaves IDLE on the next edge. `data_oe` rises OE_DELAY edges later, registered.
- With defaults: `data_oe` is high at edge 5 counting from the first edge sampling the strobe low.
- `data_oe` and `_en245` deassert on the edge where DONE sees the synced strobe high, i.e. SYNC_STAGES+1 edges after pad rise.
- `dev_wr_stb` is asserted on the edge after the q3/devsel qualifier is seen synced.
- `rom_addr` is combinational from `bank` and live `addr`, so a registered ROM has a full cycle during SETTLE.

## Configuration
- `SLOT_BUS_BANKSWITCH_EN` defined: a devsel write with `dev_reg`=4'hF loads `bank` from `data_in[log2(ROM_BANKS)-1:0]`. It does not pulse `dev_wr_stb`.
- Undefined: `bank` is tied to 0, and register F writes are forwarded as normal `dev_wr_stb` accesses.

## Structure
- Package `slot_bus_pkg`:
  - state enum (IDLE/SETTLE/ACCESS/DONE)
  - cycle-kind enum (DEV/SLOTROM/EXPROM)
  - constants `EXP_RELEASE_OFS`=11'h7FF, `BANK_REG`=4'hF
- Sub-module `slot_bus_sync`: SYNC_STAGES flop chain plus a delayed copy for fall/rise detect. Instantiated for each of the four asynchronous inputs.

## Test plan
- **Devsel read, even register:** `addr`=12'h00C, `rw`=1, `dev_q`=8'hA5, defaults → `dev_rd_stb` one pulse with `dev_reg`=4'hC; `data_oe`=1 at edge 5 with `data_out`=8'hA5; `_en245` low throughout.
- **Devsel read, odd register:** `addr`=12'h00D → `dev_rd_stb` pulses; `data_oe` stays 0.
- **Devsel write:** `data_in`=8'h3C, `q3` rising mid-cycle → `dev_wr_data`=8'h3C, exactly one `dev_wr_stb` pulse.
- **Expansion ROM ownership:**
  - iostrobe read at 12'h800 before any iosel → ignored, `_en245`=1.
  - After an iosel read at 12'h100 → the same read drives `rom_q`.
  - Read at 12'hFFF → drives data, then `exp_active`=0.
- **Bank switch** (macro on, ROM_BANKS=4): write 8'h02 to register F → `bank`=2, `rom_addr`=14'h2100 for `addr`=12'h100, no `dev_wr_stb`. Macro off → `bank`=0, `dev_wr_stb` pulses.
- **Abort and reset:** strobe low for 2 synced cycles with OE_DELAY=4 → no pulses, no drive. `reset` during ACCESS → all outputs at reset values the next edge; a still-low strobe is ignored.

Source files
------------

// File: rtl/slot_bus_pkg.sv
// Shared types and constants for the Apple II slot bus interface.
package slot_bus_pkg;

  // Bus-cycle sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // What the current bus cycle addresses.
  typedef enum logic [1:0] {
    DEV     = 2'd0,  // _devsel: device register window
    SLOTROM = 2'd1,  // _iosel: $Cn00-$CnFF slot ROM
    EXPROM  = 2'd2   // _iostrobe: $C800-$CFFF expansion ROM
  } cycle_kind_e;

  // An expansion-ROM access to $CFFF hands $C800-$CFFF back to the bus.
  localparam logic [10:0] EXP_RELEASE_OFS = 11'h7FF;

  // Device register that selects the ROM bank when bank switching is built in.
  localparam logic [3:0] BANK_REG = 4'hF;

endpackage

// File: rtl/slot_bus_sync.sv
// Synchroniser for one asynchronous slot-bus input, with a delayed copy of the
// synchronised level so the caller gets a clean one-cycle falling-edge flag.
module slot_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic fclk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Shift the pad level through the chain and keep one more stage for edge detect.
  always_ff @(posedge fclk) begin
    // NOTE: the chain resets to 0, not to the idle-high level. A strobe that is
    // already low when reset drops then never produces a falling edge; it must
    // rise (harmless) and fall again before it starts a cycle.
    if (reset) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge
      // value, so the chain shifts one stage per clock instead of collapsing.
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign fall_o = prev_q & ~chain_q[STAGES-1];

endmodule

// File: rtl/slot_bus_if.sv
// Apple II slot bus interface: synchronises the slot strobes to fclk, classifies
// each bus cycle (device register / slot ROM / expansion ROM), drives read data
// after a settle delay, tracks $C800 expansion-ROM ownership and produces
// single-cycle device read/write strobes.
// Optional feature: define SLOT_BUS_BANKSWITCH_EN to let a write to device
// register F select the ROM bank; otherwise the bank is fixed at 0.
module slot_bus_if
  import slot_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OE_DELAY    = 2,
  parameter int ROM_BANKS   = 4
) (
  input  logic                                                fclk,
  input  logic                                                reset,
  input  logic [11:0]                                         addr,
  input  logic                                                rw,
  input  logic                                                q3,
  input  logic                                                _iosel,
  input  logic                                                _iostrobe,
  input  logic                                                _devsel,
  input  logic [7:0]                                          data_in,
  input  logic [7:0]                                          rom_q,
  input  logic [7:0]                                          dev_q,
  output logic [7:0]                                          data_out,
  output logic                                                data_oe,
  output logic                                                _en245,
  output logic [12+$clog2(ROM_BANKS)-1:0]                     rom_addr,
  output logic [3:0]                                          dev_reg,
  output logic                                                dev_rd_stb,
  output logic                                                dev_wr_stb,
  output logic [7:0]                                          dev_wr_data,
  output logic                                                exp_active,
  output logic [((ROM_BANKS > 1) ? $clog2(ROM_BANKS) : 1)-1:0] bank
);

  localparam int BANK_W = (ROM_BANKS > 1) ? $clog2(ROM_BANKS) : 1;
  localparam int CNT_W  = (OE_DELAY > 1) ? $clog2(OE_DELAY) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((OE_DELAY > 0) ? OE_DELAY - 1 : 0);

  // Synchronised strobes.
  logic devsel_s, devsel_fall;
  logic iosel_s, iosel_fall;
  logic iostb_s, iostb_fall;
  logic q3_s, q3_fall_unused;

  slot_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_devsel (
    .fclk(fclk), .reset(reset), .async_i(_devsel), .sync_o(devsel_s), .fall_o(devsel_fall)
  );
  slot_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_iosel (
    .fclk(fclk), .reset(reset), .async_i(_iosel), .sync_o(iosel_s), .fall_o(iosel_fall)
  );
  slot_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_iostb (
    .fclk(fclk), .reset(reset), .async_i(_iostrobe), .sync_o(iostb_s), .fall_o(iostb_fall)
  );
  slot_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_q3 (
    .fclk(fclk), .reset(reset), .async_i(q3), .sync_o(q3_s), .fall_o(q3_fall_unused)
  );

  // Sequencer and output registers.
  state_e            state_q, state_d;
  cycle_kind_e       kind_q, kind_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [10:0]       addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              drive_q, drive_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              en245_q, en245_d;
  logic [3:0]        dev_reg_q, dev_reg_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              exp_active_q, exp_active_d;
`ifdef SLOT_BUS_BANKSWITCH_EN
  logic [BANK_W-1:0] bank_q, bank_d;
`endif

  logic strobe_hi;    // synchronised strobe of the cycle in progress is released
  logic start;
  logic enter_access;

  // Pick the strobe that owns the current cycle.
  always_comb begin
    strobe_hi = iostb_s;
    case (kind_q)
      DEV:     strobe_hi = devsel_s;
      SLOTROM: strobe_hi = iosel_s;
      default: strobe_hi = iostb_s;
    endcase
  end

  // Next-state and next-output logic for the bus-cycle sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    kind_d       = kind_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    drive_d      = drive_q;
    data_out_d   = data_out_q;
    dev_reg_d    = dev_reg_q;
    rd_stb_d     = 1'b0;
    wr_stb_d     = 1'b0;
    wr_data_d    = wr_data_q;
    exp_active_d = exp_active_q;
`ifdef SLOT_BUS_BANKSWITCH_EN
    bank_d       = bank_q;
`endif
    start        = 1'b0;
    enter_access = 1'b0;

    case (state_q)
      IDLE: begin
        // devsel > iosel > iostrobe; iosel also beats an illegal simultaneous iostrobe.
        if (devsel_fall) begin
          start  = 1'b1;
          kind_d = DEV;
        end else if (iosel_fall) begin
          start  = 1'b1;
          kind_d = SLOTROM;
        end else if (iostb_fall && exp_active_q) begin
          start  = 1'b1;
          kind_d = EXPROM;
        end

        if (start) begin
          addr_d  = addr[10:0];
          rw_d    = rw;
          // Odd device registers are strobed but never driven onto the bus.
          drive_d = rw && ((kind_d != DEV) || !addr[0]);
          cnt_d   = '0;
          if (kind_d == DEV)     dev_reg_d    = addr[3:0];
          if (kind_d == SLOTROM) exp_active_d = 1'b1;
          if (OE_DELAY == 0) begin
            state_d      = ACCESS;
            enter_access = 1'b1;
          end else begin
            state_d = SETTLE;
          end
        end
      end

      SETTLE: begin
        // A strobe released before data is driven aborts with no side effects.
        if (strobe_hi) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d      = ACCESS;
          enter_access = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ACCESS: begin
        if (kind_q == DEV && !rw_q) begin
          // Write data is valid once q3 rises, or at the latest when devsel goes away.
          if (q3_s || strobe_hi) begin
            state_d = DONE;
`ifdef SLOT_BUS_BANKSWITCH_EN
            if (addr_q[3:0] == BANK_REG) begin
              bank_d = (ROM_BANKS > 1) ? data_in[BANK_W-1:0] : '0;
            end else begin
              wr_data_d = data_in;
              wr_stb_d  = 1'b1;
            end
`else
            wr_data_d = data_in;
            wr_stb_d  = 1'b1;
`endif
          end
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (strobe_hi) begin
          state_d = IDLE;
          if (kind_q == EXPROM && addr_q == EXP_RELEASE_OFS) exp_active_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Read actions happen on the edge that enters ACCESS, from SETTLE or straight from IDLE.
    if (enter_access && rw_d) begin
      if (kind_d == DEV) rd_stb_d = 1'b1;
      if (drive_d)       data_out_d = (kind_d == DEV) ? dev_q : rom_q;
    end

    // Pad controls follow the next state so they switch on the same edge as it.
    en245_d   = (state_d == IDLE);
    data_oe_d = drive_d && (state_d == ACCESS || state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q      <= IDLE;
      kind_q       <= DEV;
      cnt_q        <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      drive_q      <= 1'b0;
      data_out_q   <= '0;
      data_oe_q    <= 1'b0;
      en245_q      <= 1'b1;
      dev_reg_q    <= '0;
      rd_stb_q     <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_data_q    <= '0;
      exp_active_q <= 1'b0;
`ifdef SLOT_BUS_BANKSWITCH_EN
      bank_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      drive_q      <= drive_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      en245_q      <= en245_d;
      dev_reg_q    <= dev_reg_d;
      rd_stb_q     <= rd_stb_d;
      wr_stb_q     <= wr_stb_d;
      wr_data_q    <= wr_data_d;
      exp_active_q <= exp_active_d;
`ifdef SLOT_BUS_BANKSWITCH_EN
      bank_q       <= bank_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_oe     = data_oe_q;
  assign _en245      = en245_q;
  assign dev_reg     = dev_reg_q;
  assign dev_rd_stb  = rd_stb_q;
  assign dev_wr_stb  = wr_stb_q;
  assign dev_wr_data = wr_data_q;
  assign exp_active  = exp_active_q;

`ifdef SLOT_BUS_BANKSWITCH_EN
  assign bank = bank_q;
`else
  assign bank = '0;
`endif

  // ROM address follows live addr so a registered ROM can settle during SETTLE.
  if (ROM_BANKS > 1) begin : g_banked
    assign rom_addr = {bank, addr};
  end else begin : g_flat
    assign rom_addr = addr;
  end

endmodule

// File: tb/tb_slot_bus_if.sv
// Directed testbench for slot_bus_if. The main instance uses default parameters;
// a second instance with OE_DELAY=4 and its own _devsel covers SETTLE abort.
// Define SLOT_BUS_BANKSWITCH_EN for both RTL and bench to exercise bank switching.
module tb_slot_bus_if;

  logic        fclk = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic        rw, q3, _iosel, _iostrobe, _devsel, _devsel2;
  logic [7:0]  data_in, rom_q, dev_q;

  logic [7:0]  data_out, dev_wr_data;
  logic        data_oe, _en245, dev_rd_stb, dev_wr_stb, exp_active;
  logic [13:0] rom_addr;
  logic [3:0]  dev_reg;
  logic [1:0]  bank;

  logic [7:0]  d2_data_out, d2_dev_wr_data;
  logic        d2_data_oe, d2_en245, d2_dev_rd_stb, d2_dev_wr_stb, d2_exp_active;
  logic [13:0] d2_rom_addr;
  logic [3:0]  d2_dev_reg;
  logic [1:0]  d2_bank;

  int errors = 0;
  int checks = 0;

  always #5 fclk = ~fclk;

  slot_bus_if dut (
    .fclk(fclk), .reset(reset), .addr(addr), .rw(rw), .q3(q3),
    ._iosel(_iosel), ._iostrobe(_iostrobe), ._devsel(_devsel),
    .data_in(data_in), .rom_q(rom_q), .dev_q(dev_q),
    .data_out(data_out), .data_oe(data_oe), ._en245(_en245), .rom_addr(rom_addr),
    .dev_reg(dev_reg), .dev_rd_stb(dev_rd_stb), .dev_wr_stb(dev_wr_stb),
    .dev_wr_data(dev_wr_data), .exp_active(exp_active), .bank(bank)
  );

  slot_bus_if #(.OE_DELAY(4)) dut2 (
    .fclk(fclk), .reset(reset), .addr(addr), .rw(rw), .q3(q3),
    ._iosel(1'b1), ._iostrobe(1'b1), ._devsel(_devsel2),
    .data_in(data_in), .rom_q(rom_q), .dev_q(dev_q),
    .data_out(d2_data_out), .data_oe(d2_data_oe), ._en245(d2_en245), .rom_addr(d2_rom_addr),
    .dev_reg(d2_dev_reg), .dev_rd_stb(d2_dev_rd_stb), .dev_wr_stb(d2_dev_wr_stb),
    .dev_wr_data(d2_dev_wr_data), .exp_active(d2_exp_active), .bank(d2_bank)
  );

  // One clock, then sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic set_strobe(input int which, input logic v);
    case (which)
      0:       _devsel    = v;
      1:       _iosel     = v;
      default: _iostrobe  = v;
    endcase
  endtask

  // Read cycle on strobe `which` (0 devsel, 1 iosel, 2 iostrobe): strobe low for
  // 8 edges, then high. Edge numbers count from the first edge sampling it low.
  task automatic do_read_cycle(input string name, input int which, input logic [11:0] a,
                               input logic taken, input logic drive, input logic [7:0] exp_data,
                               input int exp_rd, input logic exp_mid, input logic exp_end);
    int rd = 0;
    addr = a;
    rw   = 1'b1;
    set_strobe(which, 1'b0);
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (dev_rd_stb) rd++;
      if (e == 3) begin
        checks++;
        if (_en245 !== !taken) begin
          errors++; $display("FAIL %s en245@e3: got %b expected %b", name, _en245, !taken);
        end
      end
      if (e == 4) begin
        checks++;
        if (data_oe !== 1'b0) begin
          errors++; $display("FAIL %s data_oe@e4: got %b expected 0", name, data_oe);
        end
      end
      if (e == 5) begin
        checks++;
        if (data_oe !== drive) begin
          errors++; $display("FAIL %s data_oe@e5: got %b expected %b", name, data_oe, drive);
        end
        if (drive) begin
          checks++;
          if (data_out !== exp_data) begin
            errors++; $display("FAIL %s data_out@e5: got %h expected %h", name, data_out, exp_data);
          end
        end
        checks++;
        if (exp_active !== exp_mid) begin
          errors++; $display("FAIL %s exp_active@e5: got %b expected %b", name, exp_active, exp_mid);
        end
      end
      if (e == 8) set_strobe(which, 1'b1);
      if (e == 10) begin
        checks++;
        if (_en245 !== !taken) begin
          errors++; $display("FAIL %s en245@e10: got %b expected %b", name, _en245, !taken);
        end
      end
      if (e == 11) begin
        checks++;
        if (_en245 !== 1'b1 || data_oe !== 1'b0) begin
          errors++; $display("FAIL %s release@e11: got en245=%b oe=%b expected en245=1 oe=0", name, _en245, data_oe);
        end
        checks++;
        if (exp_active !== exp_end) begin
          errors++; $display("FAIL %s exp_active@e11: got %b expected %b", name, exp_active, exp_end);
        end
      end
    end
    checks++;
    if (rd !== exp_rd) begin
      errors++; $display("FAIL %s rd_stb pulses: got %0d expected %0d", name, rd, exp_rd);
    end
    tick();
    tick();
  endtask

  // Devsel write: q3 rises after edge 6, devsel released after edge 10.
  task automatic do_write(input logic [11:0] a, input logic [7:0] d,
                          output int pulses, output int first_edge, output logic oe_seen);
    pulses = 0; first_edge = -1; oe_seen = 1'b0;
    addr = a; rw = 1'b0; data_in = d; q3 = 1'b0; _devsel = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (dev_wr_stb) begin
        pulses++;
        if (first_edge < 0) first_edge = e;
      end
      if (data_oe) oe_seen = 1'b1;
      if (e == 6) q3 = 1'b1;
      if (e == 10) begin _devsel = 1'b1; q3 = 1'b0; end
    end
    data_in = 8'h00;
    rw = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (data_oe !== 1'b0 || _en245 !== 1'b1 || data_out !== 8'h00) begin
      errors++; $display("FAIL reset pads: got oe=%b en245=%b dout=%h expected 0/1/00", data_oe, _en245, data_out);
    end
    checks++;
    if (dev_rd_stb !== 1'b0 || dev_wr_stb !== 1'b0 || dev_reg !== 4'h0 || dev_wr_data !== 8'h00) begin
      errors++; $display("FAIL reset dev: got rd=%b wr=%b reg=%h wdata=%h expected all 0", dev_rd_stb, dev_wr_stb, dev_reg, dev_wr_data);
    end
    checks++;
    if (exp_active !== 1'b0 || bank !== 2'd0) begin
      errors++; $display("FAIL reset exp/bank: got exp=%b bank=%0d expected 0/0", exp_active, bank);
    end
  endtask

  task automatic test_dev_read();
    dev_q = 8'hA5;
    do_read_cycle("dev_rd_even", 0, 12'h00C, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0);
    checks++;
    if (dev_reg !== 4'hC) begin
      errors++; $display("FAIL dev_reg even: got %h expected C", dev_reg);
    end
    do_read_cycle("dev_rd_odd", 0, 12'h00D, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0);
    checks++;
    if (dev_reg !== 4'hD) begin
      errors++; $display("FAIL dev_reg odd: got %h expected D", dev_reg);
    end
  endtask

  task automatic test_dev_write();
    int   pulses, first_edge;
    logic oe_seen;
    do_write(12'h004, 8'h3C, pulses, first_edge, oe_seen);
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL wr_stb pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (first_edge !== 9) begin
      errors++; $display("FAIL wr_stb edge: got %0d expected 9", first_edge);
    end
    checks++;
    if (dev_wr_data !== 8'h3C) begin
      errors++; $display("FAIL wr_data: got %h expected 3C", dev_wr_data);
    end
    checks++;
    if (oe_seen !== 1'b0) begin
      errors++; $display("FAIL write drove bus: got oe=%b expected 0", oe_seen);
    end
  endtask

  task automatic test_exp_rom();
    rom_q = 8'h5A;
    do_read_cycle("iostb_unowned", 2, 12'h800, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    do_read_cycle("iosel_100",     1, 12'h100, 1'b1, 1'b1, 8'h5A, 0, 1'b1, 1'b1);
    do_read_cycle("iostb_owned",   2, 12'h800, 1'b1, 1'b1, 8'h5A, 0, 1'b1, 1'b1);
    do_read_cycle("iostb_cfff",    2, 12'hFFF, 1'b1, 1'b1, 8'h5A, 0, 1'b1, 1'b0);
  endtask

  task automatic test_bank_switch();
    int   pulses, first_edge;
    logic oe_seen;
    do_write(12'h00F, 8'h02, pulses, first_edge, oe_seen);
    addr = 12'h100;
    #1;
`ifdef SLOT_BUS_BANKSWITCH_EN
    checks++;
    if (bank !== 2'd2) begin
      errors++; $display("FAIL bank: got %0d expected 2", bank);
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL bank wr_stb pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (rom_addr !== 14'h2100) begin
      errors++; $display("FAIL rom_addr: got %h expected 2100", rom_addr);
    end
`else
    checks++;
    if (bank !== 2'd0) begin
      errors++; $display("FAIL bank: got %0d expected 0", bank);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL regF wr_stb pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (rom_addr !== 14'h0100 || dev_wr_data !== 8'h02) begin
      errors++; $display("FAIL regF: got rom_addr=%h wdata=%h expected 0100/02", rom_addr, dev_wr_data);
    end
`endif
  endtask

  task automatic test_abort();
    int   rd = 0;
    logic oe_seen = 1'b0;
    addr = 12'h00C; rw = 1'b1; _devsel2 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (d2_dev_rd_stb) rd++;
      if (d2_data_oe) oe_seen = 1'b1;
      if (e == 2) _devsel2 = 1'b1;
      if (e == 3) begin
        checks++;
        if (d2_en245 !== 1'b0) begin
          errors++; $display("FAIL abort en245@e3: got %b expected 0", d2_en245);
        end
      end
      if (e == 5) begin
        checks++;
        if (d2_en245 !== 1'b1) begin
          errors++; $display("FAIL abort en245@e5: got %b expected 1", d2_en245);
        end
      end
    end
    checks++;
    if (rd !== 0 || oe_seen !== 1'b0) begin
      errors++; $display("FAIL abort: got rd=%0d oe_seen=%b expected 0/0", rd, oe_seen);
    end
  endtask

  task automatic test_reset_mid();
    int rd = 0;
    int en_low = 0;
    do_read_cycle("iosel_pre_rst", 1, 12'h100, 1'b1, 1'b1, 8'h5A, 0, 1'b1, 1'b1);
    dev_q = 8'hA5; addr = 12'h00C; rw = 1'b1; _devsel = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    checks++;
    if (data_oe !== 1'b1 || data_out !== 8'hA5) begin
      errors++; $display("FAIL pre-reset drive: got oe=%b dout=%h expected 1/A5", data_oe, data_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_reset();
    for (int e = 0; e < 8; e++) begin
      tick();
      if (dev_rd_stb) rd++;
      if (!_en245) en_low++;
    end
    checks++;
    if (rd !== 0 || en_low !== 0) begin
      errors++; $display("FAIL held strobe after reset: got rd=%0d en_low=%0d expected 0/0", rd, en_low);
    end
    _devsel = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    do_read_cycle("dev_rd_recover", 0, 12'h00C, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; addr = 12'h000; rw = 1'b1; q3 = 1'b0;
    _iosel = 1'b1; _iostrobe = 1'b1; _devsel = 1'b1; _devsel2 = 1'b1;
    data_in = 8'h00; rom_q = 8'h00; dev_q = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    test_reset();
    test_dev_read();
    test_dev_write();
    test_exp_rom();
    test_bank_switch();
    test_abort();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
